nx4_tlc_receiver: RTL
=====================

Name: nx4_tlc_receiver

Overview:
Synthesizable model of the receiving end of the NX4 panel LED-driver serial interface (TLC5941-style), one driver chip per instance.
- Samples the panel signals produced by the image driver (sclk/sin/mode/xlat/blank/gsclk) in the system clock domain.
- Shifts in grayscale or dot-correction frames and latches them on xlat.
- Generates 16 PWM channel outputs from gsclk and blank, and reports framing errors on an active-low xerr.
- Used for in-FPGA loopback checking and as the DUT-side model in image driver benches.

Parameters:
CHANNELS, 16, number of PWM output channels
GS_BITS, 12, grayscale bits per channel
DC_BITS, 6, dot-correction bits per channel
SYNC_STAGES, 2, synchronizer flops on each sampled input (minimum 2)

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
led_sclk  input  1  serial shift clock, asynchronous to clock
led_sin  input  1  serial data, MSB first
led_mode  input  1  0 = grayscale frame, 1 = dot-correction frame
led_xlat  input  1  latch strobe, acts on rising edge
led_blank  input  1  high = all outputs off, GS counter cleared
led_gsclk  input  1  grayscale PWM clock
led_sout  output  1  MSB of shift register, for daisy-chaining
led_xerr  output  1  active-low framing error, sticky
channel_on  output  CHANNELS  PWM state per channel, bit i = channel i
gs_count  output  GS_BITS  current PWM counter
dc_value  output  CHANNELS*DC_BITS  latched dot-correction data; not applied to PWM

Behaviour:
- Reset values: led_sout=0, led_xerr=1, channel_on=0, gs_count=0, dc_value=0. Shift register, GS latch and bit_count are also cleared.
- Reset mid-frame discards all partial data. The first sclk edge after reset is bit 0.
- Input sync: all six inputs pass through SYNC_STAGES flops.
  - Rising-edge detect on sync'd sclk, xlat and gsclk adds 1 cycle.
  - Latency from pin edge to action is SYNC_STAGES+1 clocks.
  - sin, mode and blank are sync'd with the same depth, so sin stays aligned with the sclk edge.
- Shift register: GS_FRAME = CHANNELS*GS_BITS = 192 bits.
  - On each sclk edge: shift left, sync'd sin enters the LSB.
  - led_sout = shift_reg[GS_FRAME-1], registered.
- bit_count: 8 bits, increments per sclk edge, saturates at 255.
- On xlat edge:
  - mode=0: gs_latch <= shift_reg[191:0]. Channel i = bits [12i+11:12i], so channel 15 is shifted in first.
  - mode=1: dc_value <= shift_reg[95:0] (DC_FRAME=96). Channel i = bits [6i+5:6i]. gs_latch is unchanged.
  - If bit_count equals the expected length for the current mode: led_xerr <= 1. Otherwise led_xerr <= 0.
  - bit_count <= 0 in both cases.
- sclk and xlat edges in the same cycle: the shift is applied first. The latch captures the post-shift register, and the compare uses bit_count+1.
- Mode only matters at the xlat edge; changing mode mid-shift has no effect.
- GS counter:
  - blank high: gs_count <= 0 and gsclk edges are ignored.
  - blank low: each gsclk edge increments gs_count, saturating at 4095 (no wrap).
- channel_on[i] = !blank_sync && (gs_count < gs_latch[i]), registered, 1-cycle latency.
  - gs_latch=0 means the channel is never on.
  - gs_latch=4095 means on for 4095 gsclks after blank falls.
- xlat while blank is low: new values take effect on the next compare; gs_count is not reset.

Decomposition:
- Package nx4_pkg holds:
  - CHANNELS, GS_BITS, DC_BITS
  - GS_FRAME=192 and DC_FRAME=96 localparams
  - MODE_GS=0 and MODE_DC=1 constants
- Sub-module nx4_edge_sync: SYNC_STAGES-deep synchronizer with optional rising-edge pulse output. Instantiated per input; the edge output is used for sclk, xlat and gsclk.

Test Plan:
- Reset check: pulse reset 3 cycles with inputs idle -> led_xerr=1, channel_on=0, gs_count=0, led_sout=0.
- GS frame:
  - Stimulus: shift 192 bits with ch15=0xFFF, ch1=0x002, all others 0, then xlat with mode=0, blank low, 3 gsclk pulses.
  - Response: xerr stays 1. After gsclk 1 (gs_count=1), ch1 and ch15 are on. After gsclk 2 and 3 (gs_count=2, 3), ch1 is off and ch15 stays on.
- Framing error: shift 191 bits then xlat -> led_xerr=0 within SYNC_STAGES+2 clocks. Next correct 192-bit frame + xlat -> led_xerr=1.
- DC frame: shift 96 bits of 0x3F per channel with mode=1, then xlat -> dc_value all ones, gs_latch unchanged, xerr=1. A 192-bit frame with mode=1 -> xerr=0.
- Blank and saturation:
  - 5000 gsclk pulses with blank low -> gs_count saturates at 4095. A channel set to 4095 turns off at count 4095.
  - Raising blank mid-count -> gs_count=0 and channel_on=0 one cycle after sync.
- Simultaneous edges: final sclk edge and xlat edge coincide after 191 prior edges -> frame latched including the final bit, xerr=1, bit_count=0.

Source files
------------

// File: rtl/nx4_pkg.sv
// Shared constants and types for the NX4 TLC-style panel receiver.
package nx4_pkg;

  localparam int CHANNELS = 16;
  localparam int GS_BITS  = 12;
  localparam int DC_BITS  = 6;

  localparam int GS_FRAME = CHANNELS * GS_BITS;
  localparam int DC_FRAME = CHANNELS * DC_BITS;

  // Width of the per-frame sclk edge counter; saturates at its all-ones value.
  localparam int CNT_W = 8;

  typedef enum logic {
    MODE_GS = 1'b0,
    MODE_DC = 1'b1
  } frame_mode_e;

endpackage

// File: rtl/nx4_edge_sync.sv
// Multi-flop synchronizer for one asynchronous pin, with an optional
// single-cycle rising-edge pulse derived from the synchronized level.
module nx4_edge_sync #(
  parameter int STAGES  = 2,
  parameter bit EDGE_EN = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign level_o = sync_q[STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic prev_q;

      always_ff @(posedge clock) begin
        if (reset) begin
          prev_q <= 1'b0;
        end else begin
          prev_q <= sync_q[STAGES-1];
        end
      end

      assign rise_o = sync_q[STAGES-1] & ~prev_q;
    end else begin : g_no_edge
      assign rise_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/nx4_tlc_receiver.sv
// Receiving end of the NX4 LED-driver serial link: shifts and latches GS/DC
// frames, flags framing errors and drives per-channel PWM from gsclk.
module nx4_tlc_receiver #(
  parameter int CHANNELS    = nx4_pkg::CHANNELS,
  parameter int GS_BITS     = nx4_pkg::GS_BITS,
  parameter int DC_BITS     = nx4_pkg::DC_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         led_sclk,
  input  logic                         led_sin,
  input  logic                         led_mode,
  input  logic                         led_xlat,
  input  logic                         led_blank,
  input  logic                         led_gsclk,
  output logic                         led_sout,
  output logic                         led_xerr,
  output logic [CHANNELS-1:0]          channel_on,
  output logic [GS_BITS-1:0]           gs_count,
  output logic [CHANNELS*DC_BITS-1:0]  dc_value
);

  import nx4_pkg::*;

  localparam int GS_LEN = CHANNELS * GS_BITS;
  localparam int DC_LEN = CHANNELS * DC_BITS;
  localparam logic [CNT_W-1:0] GS_LEN_CNT = CNT_W'(GS_LEN);
  localparam logic [CNT_W-1:0] DC_LEN_CNT = CNT_W'(DC_LEN);

  logic sclk_rise, xlat_rise, gsclk_rise;
  logic sin_s, mode_s, blank_s;
  logic unused_sclk_lvl, unused_xlat_lvl, unused_gsclk_lvl;
  logic unused_sin_rise, unused_mode_rise, unused_blank_rise;

  nx4_edge_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_sclk (
    .clock(clock), .reset(reset), .d_i(led_sclk),
    .level_o(unused_sclk_lvl), .rise_o(sclk_rise)
  );
  nx4_edge_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_xlat (
    .clock(clock), .reset(reset), .d_i(led_xlat),
    .level_o(unused_xlat_lvl), .rise_o(xlat_rise)
  );
  nx4_edge_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_gsclk (
    .clock(clock), .reset(reset), .d_i(led_gsclk),
    .level_o(unused_gsclk_lvl), .rise_o(gsclk_rise)
  );
  // Level-only pins use the same depth so sin lines up with its sclk edge.
  nx4_edge_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_sin (
    .clock(clock), .reset(reset), .d_i(led_sin),
    .level_o(sin_s), .rise_o(unused_sin_rise)
  );
  nx4_edge_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_mode (
    .clock(clock), .reset(reset), .d_i(led_mode),
    .level_o(mode_s), .rise_o(unused_mode_rise)
  );
  nx4_edge_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_blank (
    .clock(clock), .reset(reset), .d_i(led_blank),
    .level_o(blank_s), .rise_o(unused_blank_rise)
  );

  logic [GS_LEN-1:0]   shift_q,    shift_d;
  logic [GS_LEN-1:0]   gs_latch_q, gs_latch_d;
  logic [DC_LEN-1:0]   dc_q,       dc_d;
  logic [CNT_W-1:0]    bit_cnt_q,  bit_cnt_d;
  logic [GS_BITS-1:0]  gs_cnt_q,   gs_cnt_d;
  logic [CHANNELS-1:0] chan_q,     chan_d;
  logic                xerr_q,     xerr_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    shift_d    = shift_q;
    gs_latch_d = gs_latch_q;
    dc_d       = dc_q;
    bit_cnt_d  = bit_cnt_q;
    gs_cnt_d   = gs_cnt_q;
    xerr_d     = xerr_q;
    chan_d     = '0;

    if (sclk_rise) begin
      shift_d = {shift_q[GS_LEN-2:0], sin_s};
      if (bit_cnt_q != '1) begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end

    // A coincident sclk edge is already folded into shift_d / bit_cnt_d here.
    if (xlat_rise) begin
      if (mode_s == MODE_DC) begin
        dc_d   = shift_d[DC_LEN-1:0];
        xerr_d = (bit_cnt_d == DC_LEN_CNT);
      end else begin
        gs_latch_d = shift_d;
        xerr_d     = (bit_cnt_d == GS_LEN_CNT);
      end
      bit_cnt_d = '0;
    end

    if (blank_s) begin
      gs_cnt_d = '0;
    end else if (gsclk_rise && (gs_cnt_q != '1)) begin
      gs_cnt_d = gs_cnt_q + 1'b1;
    end

    for (int i = 0; i < CHANNELS; i++) begin
      chan_d[i] = !blank_s && (gs_cnt_q < gs_latch_q[i*GS_BITS +: GS_BITS]);
    end
  end

  // NOTE: the shift register and latches are reset too, so a frame cut off by reset is discarded.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q    <= '0;
      gs_latch_q <= '0;
      dc_q       <= '0;
      bit_cnt_q  <= '0;
      gs_cnt_q   <= '0;
      chan_q     <= '0;
      xerr_q     <= 1'b1;
    end else begin
      shift_q    <= shift_d;
      gs_latch_q <= gs_latch_d;
      dc_q       <= dc_d;
      bit_cnt_q  <= bit_cnt_d;
      gs_cnt_q   <= gs_cnt_d;
      chan_q     <= chan_d;
      xerr_q     <= xerr_d;
    end
  end

  assign led_sout   = shift_q[GS_LEN-1];
  assign led_xerr   = xerr_q;
  assign channel_on = chan_q;
  assign gs_count   = gs_cnt_q;
  assign dc_value   = dc_q;

endmodule
